// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: 1149.1 TAP slave with IR, BYPASS and NUM_DR user DRs.
// Optional IDCODE register enabled by defining JTAG_TAP_IDCODE_EN.
module jtag_tap_ctrl #(
  parameter int unsigned IR_W       = 4,
  parameter int unsigned NUM_DR     = 4,
  parameter int unsigned DR_W       = 16,
  parameter int unsigned DR_BASE    = 2,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                     tck,
  input  logic                     trst,
  input  logic                     tms,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_en,
  output logic [3:0]               tap_state,
  output logic [IR_W-1:0]          ir_out,
  input  logic [NUM_DR*DR_W-1:0]   dr_capture_data,
  output logic [NUM_DR*DR_W-1:0]   dr_update_data,
  output logic [NUM_DR-1:0]        dr_update_pulse
);

  typedef enum logic [3:0] {
    TLR   = 4'hF, RTI   = 4'hC,
    SELDR = 4'h7, CAPDR = 4'h6,
    SHDR  = 4'h2, EX1DR = 4'h1,
    PAUDR = 4'h3, EX2DR = 4'h0,
    UPDDR = 4'h5, SELIR = 4'h4,
    CAPIR = 4'hE, SHIR  = 4'hA,
    EX1IR = 4'h9, PAUIR = 4'hB,
    EX2IR = 4'h8, UPDIR = 4'hD
  } state_t;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] RST_OP = IR_W'(1);
`else
  localparam logic [IR_W-1:0] RST_OP = {IR_W{1'b1}};
`endif
  localparam logic [IR_W-1:0] IR_CAP = IR_W'(1);

  state_t              r_state;
  logic [IR_W-1:0]     r_ir_shift;
  logic [IR_W-1:0]     r_ir_out;
  logic                r_byp;
  logic [DR_W-1:0]     r_dr_shift;
  logic [NUM_DR*DR_W-1:0] r_upd_data;
  logic [NUM_DR-1:0]   r_upd_pulse;

  logic [NUM_DR-1:0]   w_dr_sel;
  logic                w_dr_hit;
  logic [DR_W-1:0]     w_cap;
  logic                w_sel_byp;
  logic                w_dr_lsb;
  logic [DR_W-1:0]     w_dr_next;

  function automatic state_t f_next(state_t s, logic m);
    f_next = s;
    unique case (s)
      TLR:   f_next = m ? TLR   : RTI;
      RTI:   f_next = m ? SELDR : RTI;
      SELDR: f_next = m ? SELIR : CAPDR;
      CAPDR: f_next = m ? EX1DR : SHDR;
      SHDR:  f_next = m ? EX1DR : SHDR;
      EX1DR: f_next = m ? UPDDR : PAUDR;
      PAUDR: f_next = m ? EX2DR : PAUDR;
      EX2DR: f_next = m ? UPDDR : SHDR;
      UPDDR: f_next = m ? SELDR : RTI;
      SELIR: f_next = m ? TLR   : CAPIR;
      CAPIR: f_next = m ? EX1IR : SHIR;
      SHIR:  f_next = m ? EX1IR : SHIR;
      EX1IR: f_next = m ? UPDIR : PAUIR;
      PAUIR: f_next = m ? EX2IR : PAUIR;
      EX2IR: f_next = m ? UPDIR : SHIR;
      UPDIR: f_next = m ? SELDR : RTI;
    endcase
  endfunction

  // Decode the active instruction into a one-hot user DR select.
  always_comb begin
    w_dr_sel = '0;
    w_cap    = '0;
    for (int k = 0; k < int'(NUM_DR); k++) begin
      if (r_ir_out == IR_W'(DR_BASE + k)) begin
        w_dr_sel[k] = 1'b1;
        w_cap       = dr_capture_data[k*DR_W +: DR_W];
      end
    end
  end

  assign w_dr_hit  = |w_dr_sel;
  assign w_dr_next = (r_dr_shift >> 1) | (DR_W'(tdi) << (DR_W - 1));

`ifdef JTAG_TAP_IDCODE_EN
  logic        w_sel_idc;
  logic [31:0] r_idc;
  assign w_sel_idc = (r_ir_out == IR_W'(1));
  assign w_sel_byp = !w_dr_hit && !w_sel_idc;

  // IDCODE register: capture the fixed ID, then shift it out LSB first.
  always_ff @(posedge tck) begin
    if (trst)
      r_idc <= '0;
    else if (w_sel_idc && r_state == CAPDR)
      r_idc <= IDCODE_VAL;
    else if (w_sel_idc && r_state == SHDR)
      r_idc <= {tdi, r_idc[31:1]};
  end
`else
  logic w_unused_idc;
  assign w_unused_idc = ^IDCODE_VAL;
  assign w_sel_byp    = !w_dr_hit;
`endif

  // Select the serial output of whichever DR is active.
  always_comb begin
    w_dr_lsb = r_byp;
    if (w_dr_hit)
      w_dr_lsb = r_dr_shift[0];
`ifdef JTAG_TAP_IDCODE_EN
    if (w_sel_idc)
      w_dr_lsb = r_idc[0];
`endif
  end

  // TAP state machine advances on tms every tck.
  always_ff @(posedge tck) begin
    if (trst)
      r_state <= TLR;
    else
      r_state <= f_next(r_state, tms);
  end

  // Instruction register: capture, shift and commit on UpdIR.
  always_ff @(posedge tck) begin
    if (trst) begin
      r_ir_shift <= '0;
      r_ir_out   <= RST_OP;
    end else begin
      unique case (r_state)
        TLR:     r_ir_out   <= RST_OP;
        CAPIR:   r_ir_shift <= IR_CAP;
        SHIR:    r_ir_shift <= {tdi, r_ir_shift[IR_W-1:1]};
        UPDIR:   r_ir_out   <= r_ir_shift;
        default: ;
      endcase
    end
  end

  // Shared user-DR shifter and the BYPASS bit.
  always_ff @(posedge tck) begin
    if (trst) begin
      r_dr_shift <= '0;
      r_byp      <= 1'b0;
    end else if (r_state == CAPDR) begin
      if (w_dr_hit)  r_dr_shift <= w_cap;
      if (w_sel_byp) r_byp      <= 1'b0;
    end else if (r_state == SHDR) begin
      if (w_dr_hit)  r_dr_shift <= w_dr_next;
      if (w_sel_byp) r_byp      <= tdi;
    end
  end

  // Commit the shifted value to the selected DR and strobe it once.
  always_ff @(posedge tck) begin
    if (trst) begin
      r_upd_data  <= '0;
      r_upd_pulse <= '0;
    end else begin
      r_upd_pulse <= '0;
      if (r_state == UPDDR) begin
        for (int k = 0; k < int'(NUM_DR); k++) begin
          if (w_dr_sel[k]) begin
            r_upd_data[k*DR_W +: DR_W] <= r_dr_shift;
            r_upd_pulse[k]             <= 1'b1;
          end
        end
      end
    end
  end

  assign tdo = (r_state == SHIR) ? r_ir_shift[0] :
               (r_state == SHDR) ? w_dr_lsb : 1'b0;
  assign tdo_en          = (r_state == SHIR) || (r_state == SHDR);
  assign tap_state       = r_state;
  assign ir_out          = r_ir_out;
  assign dr_update_data  = r_upd_data;
  assign dr_update_pulse = r_upd_pulse;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: directed scans with a queue-based scoreboard.
// Expected tdo bits and update events are checked by a separate monitor.
module tb_jtag_tap_ctrl;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [3:0]  RST_OP  = 4'h1;
  localparam logic [31:0] ID_EXP  = 32'h1000_0001;
`else
  localparam logic [3:0]  RST_OP  = 4'hF;
  localparam logic [31:0] ID_EXP  = 32'hE1E1_E1E0;
`endif
  localparam logic [63:0] CAP =
    {16'hBEEF, 16'h1234, 16'h5A5A, 16'h0F0F};

  logic        tck = 1'b0;
  logic        trst, tms, tdi;
  logic        tdo, tdo_en;
  logic [3:0]  tap_state;
  logic [3:0]  ir_out;
  logic [63:0] dr_capture_data;
  logic [63:0] dr_update_data;
  logic [3:0]  dr_update_pulse;

  jtag_tap_ctrl dut (
    .tck             (tck),
    .trst            (trst),
    .tms             (tms),
    .tdi             (tdi),
    .tdo             (tdo),
    .tdo_en          (tdo_en),
    .tap_state       (tap_state),
    .ir_out          (ir_out),
    .dr_capture_data (dr_capture_data),
    .dr_update_data  (dr_update_data),
    .dr_update_pulse (dr_update_pulse)
  );

  always #5 tck = ~tck;

  typedef struct packed {
    logic [3:0]  pulse;
    logic [63:0] data;
  } upd_t;

  logic        tdo_q[$];
  upd_t        upd_q[$];
  logic [63:0] upd_model;
  int          n_run  = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  // From RTI: load op into IR, return to RTI.
  task automatic ir_scan(input logic [3:0] op);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) begin
      tdo_q.push_back(i == 0);
      step(i == 3, op[i]);
    end
    step(1, 0);
    step(0, 0);
    chk($sformatf("ir_out_%h", op), 64'(ir_out), 64'(op));
  endtask

  // From RTI: n-bit DR scan; k<0 means no update expected.
  task automatic dr_scan(input int n, input logic [31:0] din,
                         input logic [31:0] dexp, input int k,
                         input logic [15:0] uval);
    step(1, 0); step(0, 0);
    if (n == 0) begin
      step(1, 0);
    end else begin
      step(0, 0);
      for (int i = 0; i < n; i++) begin
        tdo_q.push_back(dexp[i]);
        step(i == n - 1, din[i]);
      end
    end
    step(1, 0);
    if (k >= 0) begin
      upd_model[k*16 +: 16] = uval;
      upd_q.push_back('{pulse: 4'(1 << k), data: upd_model});
    end
    step(0, 0);
    step(0, 0);
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge tck) begin
    if (tdo_en) begin
      if (tdo_q.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL tdo_unexp: got tdo=%b expected no shift", tdo);
      end else begin
        chk("tdo", 64'(tdo), 64'(tdo_q.pop_front()));
      end
    end
    if (|dr_update_pulse) begin
      if (upd_q.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL pulse_unexp: got %b expected 0000",
                 dr_update_pulse);
      end else begin
        upd_t e;
        e = upd_q.pop_front();
        chk("upd_pulse", 64'(dr_update_pulse), 64'(e.pulse));
        chk("upd_data", dr_update_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dr_capture_data = CAP;
    upd_model = '0;
    trst = 1'b1; tms = 1'b1; tdi = 1'b0;
    step(1, 0); step(1, 0);
    trst = 1'b0;
    chk("rst_state", 64'(tap_state), 64'hF);
    chk("rst_ir", 64'(ir_out), 64'(RST_OP));
    chk("rst_upd", dr_update_data, 64'h0);
    chk("rst_pulse", 64'(dr_update_pulse), 64'h0);
    chk("rst_tdo", 64'({tdo_en, tdo}), 64'h0);

    step(0, 0); step(1, 0); step(0, 0); step(1, 0); step(0, 0);
    chk("pause_dr", 64'(tap_state), 64'h3);
    for (int i = 0; i < 5; i++) begin
      step(1, 0);
      if (i == 3) chk("sel_ir", 64'(tap_state), 64'h4);
    end
    chk("tms5_tlr", 64'(tap_state), 64'hF);
    chk("tms5_ir", 64'(ir_out), 64'(RST_OP));
    step(0, 0);
    chk("rti", 64'(tap_state), 64'hC);

    ir_scan(4'h3);
    dr_scan(16, 32'hA5C3, 32'h5A5A, 1, 16'hA5C3);
    ir_scan(4'h4);
    dr_scan(16, 32'h00FF, 32'h1234, 2, 16'h00FF);
    ir_scan(4'h5);
    dr_scan(0, 32'h0, 32'h0, 3, 16'hBEEF);
    ir_scan(4'hF);
    dr_scan(4, 32'hD, 32'hA, -1, 16'h0);
    ir_scan(4'h0);
    dr_scan(2, 32'h3, 32'h2, -1, 16'h0);
    chk("upd_hold", dr_update_data, upd_model);

    ir_scan(4'h3);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 3; i++) begin
      tdo_q.push_back(CAP[16 + i]);
      step(0, 1);
    end
    tdo_q.push_back(CAP[19]);
    trst = 1'b1;
    step(0, 0);
    trst = 1'b0;
    upd_model = '0;
    chk("mid_state", 64'(tap_state), 64'hF);
    chk("mid_ir", 64'(ir_out), 64'(RST_OP));
    chk("mid_upd", dr_update_data, 64'h0);
    step(0, 0);
    step(0, 0);
    dr_scan(32, 32'hF0F0_F0F0, ID_EXP, -1, 16'h0);

    step(0, 0); step(0, 0);
    chk("tdo_q_left", 64'(tdo_q.size()), 64'h0);
    chk("upd_q_left", 64'(upd_q.size()), 64'h0);
    chk("upd_final", dr_update_data, upd_model);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- Parametrised IEEE 1149.1-style TAP controller. Serves as the DUT-side slave for the existing JTAG master/monitor interfaces.
- Contains the 16-state TAP FSM, an IR_W-bit instruction register, a 1-bit BYPASS register, an optional IDCODE register, and NUM_DR user data registers of DR_W bits each.
- Fully synchronous to tck; no negedge logic.
- Successor to the fixed single-chain slave, generalised in IR width, DR count and DR width.

Parameters:
- IR_W, 4: instruction register width, minimum 2.
- NUM_DR, 4: number of user data registers, minimum 1.
- DR_W, 16: width of each user data register, minimum 1.
- DR_BASE, 2: opcode of user DR 0. User DR k uses opcode DR_BASE+k.
  - Requires DR_BASE >= 2.
  - Requires DR_BASE+NUM_DR-1 < 2^IR_W-1.
- IDCODE_VAL, 32'h1000_0001: IDCODE capture value, bit 0 must be 1. Used only with the optional feature.

Ports:
- tck, in, 1: TAP clock, all state on posedge.
- trst, in, 1: synchronous active-high reset.
- tms, in, 1: mode select, sampled on posedge.
- tdi, in, 1: serial data in, sampled on posedge.
- tdo, out, 1: serial data out.
- tdo_en, out, 1: high while tdo is valid.
- tap_state, out, 4: current FSM state (standard 1149.1 encoding).
- ir_out, out, IR_W: active instruction.
- dr_capture_data, in, NUM_DR*DR_W: parallel capture values; slice k belongs to DR k.
- dr_update_data, out, NUM_DR*DR_W: parallel update registers; slice k belongs to DR k.
- dr_update_pulse, out, NUM_DR: one-cycle strobe per DR.

Behaviour:
- Reset (trst=1 at posedge) forces:
  - state = TEST_LOGIC_RESET
  - ir_out = reset opcode (see Optional Feature)
  - dr_update_data = 0, dr_update_pulse = 0
  - all shift registers = 0, tdo = 0, tdo_en = 0
- Reset overrides everything, including mid-shift; partially shifted data is discarded and nothing is updated.
- FSM: the 16 standard states and transitions on tms at each posedge.
  - Encoding: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
  - tms=1 for 5 consecutive posedges reaches TLR from any state.
  - While in TLR, ir_out is reloaded with the reset opcode every cycle.
- Instruction register:
  - CapIR: ir_shift <= {0...,2'b01}.
  - ShIR: ir_shift <= {tdi, ir_shift[IR_W-1:1]}.
  - UpdIR: ir_out <= ir_shift. The new instruction is effective from the next cycle.
  - Pause and Exit states hold the shift register.
- Decode of ir_out:
  - All ones selects BYPASS.
  - DR_BASE+k selects user DR k.
  - 1 selects IDCODE (feature on only).
  - Every other opcode, including 0, selects BYPASS.
- Data register capture (CapDR):
  - User DR k: shift <= dr_capture_data slice k.
  - BYPASS: bypass <= 0.
  - IDCODE: 32-bit shift <= IDCODE_VAL.
- Data register shift (ShDR): the selected register shifts right with tdi entering the MSB; Pause and Exit hold.
- Data register update (UpdDR):
  - User DR k: dr_update_data slice k <= shift, and dr_update_pulse[k]=1 for exactly the one cycle after UpdDR.
  - BYPASS and IDCODE update nothing.
  - Unselected DRs are never modified.
- tdo:
  - Combinational LSB of the selected shift register (IR in ShIR, selected DR in ShDR); 0 otherwise.
  - tdo_en = 1 exactly when state is ShIR or ShDR.
  - Shifting N bits through a user DR: tdo presents captured bit i during the i-th ShDR cycle, so the first bit is visible on entering ShDR.
  - BYPASS gives tdi-to-tdo latency of one shift cycle.
- Capture and update happen only in CapxR and UpdxR respectively. Entering UpdDR via Ex1DR with zero shifts still updates with the captured value.

Optional Feature:
- Macro: JTAG_TAP_IDCODE_EN.
- Defined:
  - 32-bit IDCODE register present, opcode 1.
  - Reset and TLR opcode = 1, so the first DR scan after reset reads IDCODE_VAL.
- Undefined:
  - No IDCODE register; opcode 1 decodes as BYPASS.
  - Reset and TLR opcode = all ones (BYPASS).
  - IDCODE_VAL is ignored.

Test Plan:
- FSM return to TLR: reset; reach PauDR; drive tms=1,1,1,1,1 -> tap_state=F after the 5th posedge; ir_out=reset opcode.
- IR scan: IR_W=4; shift 4'h3 LSB first through ShIR -> tdo during shift shows 1,0,0,0 (capture pattern); after UpdIR ir_out=4'h3.
- User DR write: select DR1 (opcode 3); shift 16'hA5C3 -> dr_update_data slice 1 = A5C3; dr_update_pulse = 4'b0010 for one cycle; other slices unchanged.
- User DR read: dr_capture_data slice 2 = 16'h1234; ir_out=4; capture and shift 16 bits -> tdo sequence = 1234 LSB first.
- BYPASS: ir_out=F; shift tdi pattern 1,0,1,1 -> tdo = 0,1,0,1.
- Reset mid-shift and IDCODE: with JTAG_TAP_IDCODE_EN, trst during ShDR -> no pulse, ir_out=1, next DR scan yields 32'h1000_0001 LSB first. Without the macro -> ir_out=F.
